bram_copy_engine: RTL and testbench
===================================

# bram_copy_engine

Parametrised BRAM-to-BRAM transfer engine for the accelerator datapath. It moves a block of words from a source BRAM port to a destination BRAM port, or fills a destination range with a constant. It replaces the address-sweep-and-loopback procedure used to stage matrices between BRAMs. It sustains one word per clock and accounts for the one-cycle BRAM read latency. A start/busy/done handshake exposes it to the controller.

## Interface
- ADDR_WIDTH, 15: BRAM byte-address width.
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- LEN_WIDTH, 13: width of the word-count field.
- BRAM_CLK  in  1  single clock; all logic is on its rising edge.
- BRAM_RST  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill; latched at start.
- src_base  in  ADDR_WIDTH  source byte address of the first word; latched at start.
- dst_base  in  ADDR_WIDTH  destination byte address of the first word; latched at start.
- len  in  LEN_WIDTH  number of words; latched at start.
- fill_value  in  DATA_WIDTH  constant written in fill mode; latched at start.
- abort  in  1  terminates a running transfer.
- busy  out  1  high from the first access cycle through the last write cycle.
- done  out  1  one-cycle completion pulse.
- words_done  out  LEN_WIDTH  number of words written so far in the current or last transfer.
- SRC_ADDR  out  ADDR_WIDTH  source BRAM address.
- SRC_EN  out  1  source read enable.
- SRC_WE  out  DATA_WIDTH/8  tied to 0.
- SRC_RDDATA  in  DATA_WIDTH  source read data, valid the cycle after SRC_EN.
- DST_ADDR  out  ADDR_WIDTH  destination BRAM address.
- DST_EN  out  1  destination enable.
- DST_WE  out  DATA_WIDTH/8  all ones on write cycles, otherwise 0.
- DST_WRDATA  out  DATA_WIDTH  SRC_RDDATA in copy mode, latched fill_value in fill mode.

## Operation
- Address step is STEP = DATA_WIDTH/8 bytes per word.
- Addresses wrap modulo 2^ADDR_WIDTH; there is no error and no saturation.
- FSM states:
  - IDLE: `start` moves to RUN if len ≠ 0, or to DONE if len = 0. Parameters are latched and the read counter and words_done are cleared.
  - RUN: issue read k (k = 0..len-1) at src_base + k·STEP with SRC_EN = 1; SRC_EN is asserted in copy mode only. After the last read, go to DRAIN.
  - DRAIN: one cycle in which the final write is performed, then go to DONE.
  - DONE: done = 1 for one cycle, then return to IDLE.
- Write pipeline: a write-valid flag is the read-valid flag delayed one cycle. The write address register is the read address register delayed one cycle, rebased to dst_base + k·STEP.
- Fill mode runs the same schedule and the same cycle count as copy mode, but SRC_EN stays 0.
- words_done increments on every write cycle and holds its value in IDLE until the next start.
- start while not in IDLE is ignored.
- abort in RUN or DRAIN: no further reads are issued. A write whose read was issued in the previous cycle still completes. Next state is DONE. words_done reflects the writes actually performed.
- abort and start in the same IDLE cycle: start wins; abort is ignored.

## Timing
- Cycle 0 is the IDLE cycle in which start = 1.
- Reads occur in cycles 1..N and writes in cycles 2..N+1.
- busy is high in cycles 1..N+1. done pulses in cycle N+2 and is low everywhere else.
- Throughput is one word per cycle with no bubbles.
- len = 0: no SRC_EN and no DST_WE; busy stays 0; done pulses in cycle 1; words_done = 0.
- The next start is accepted in cycle N+3 at the earliest.
- Reset (BRAM_RST = 0) takes effect asynchronously:
  - state goes to IDLE;
  - busy, done, SRC_EN, DST_EN, DST_WE and words_done are all 0;
  - SRC_ADDR, DST_ADDR and the latched fields are all 0;
  - any in-flight write is dropped.
- After reset release, the first start is honoured in the first clock cycle.

## Test plan
- Copy test: preload the source BRAM with word i = i at 0..2047. Request copy with src_base = 0, dst_base = 0x4000, len = 2048. Required: every destination word matches its source word; done pulses exactly at cycle 2050; words_done = 2048; exactly 2048 DST_WE cycles.
- Fill test: request fill with fill_value = 0xDEADBEEF, dst_base = 0x100, len = 5. Required: addresses 0x100..0x110 hold 0xDEADBEEF; SRC_EN is never asserted; 0x114 is unchanged.
- Wrap test: ADDR_WIDTH = 15, dst_base = 0x7FF8, len = 4. Required: writes go to 0x7FF8, 0x7FFC, 0x0000, 0x0004.
- Zero length, then busy start: len = 0 gives done at cycle 1 with no accesses. A second start issued during a len = 8 run is ignored; exactly 8 writes occur.
- Abort test: len = 100 with abort in cycle 10 (reads 0..9 issued). Required: writes 0..9 complete; done pulses at cycle 11; words_done = 10.
- Reset test: assert BRAM_RST low in cycle 5 of a len = 50 copy. Required: all outputs are 0 immediately; no further DST_WE; a fresh start after release runs normally.

Source files
------------

// File: rtl/bram_copy_engine.sv
// BRAM-to-BRAM block copy / constant fill engine, one word per clock.
// The write stage trails the read stage by one cycle to absorb BRAM read latency.
`timescale 1ns/1ps
module bram_copy_engine #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 13
) (
    input  logic                    BRAM_CLK,
    input  logic                    BRAM_RST,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ADDR_WIDTH-1:0]   src_base,
    input  logic [ADDR_WIDTH-1:0]   dst_base,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic [DATA_WIDTH-1:0]   fill_value,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_WIDTH-1:0]    words_done,
    output logic [ADDR_WIDTH-1:0]   SRC_ADDR,
    output logic                    SRC_EN,
    output logic [DATA_WIDTH/8-1:0] SRC_WE,
    input  logic [DATA_WIDTH-1:0]   SRC_RDDATA,
    output logic [ADDR_WIDTH-1:0]   DST_ADDR,
    output logic                    DST_EN,
    output logic [DATA_WIDTH/8-1:0] DST_WE,
    output logic [DATA_WIDTH-1:0]   DST_WRDATA
);

    // state | meaning
    // IDLE  | waiting for start; words_done holds last count
    // RUN   | one read per cycle, write of previous read in flight
    // DRAIN | final write, no read
    // DONE  | done pulse, back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BE_W);

    state_t                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]  src_base_q, src_base_d;
    logic [ADDR_WIDTH-1:0]  dst_base_q, dst_base_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [DATA_WIDTH-1:0]  fill_q, fill_d;
    logic [LEN_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0]  src_addr_q, src_addr_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   src_en_q, src_en_d;
    logic [ADDR_WIDTH-1:0]  dst_addr_q, dst_addr_d;
    logic                   wr_valid_q, wr_valid_d;
    logic [LEN_WIDTH-1:0]   words_done_q, words_done_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        src_base_d   = src_base_q;
        dst_base_d   = dst_base_q;
        len_d        = len_q;
        fill_d       = fill_q;
        rd_cnt_d     = rd_cnt_q;
        src_addr_d   = src_addr_q;
        rd_valid_d   = 1'b0;
        src_en_d     = 1'b0;
        done_d       = 1'b0;
        wr_valid_d   = rd_valid_q;
        // Write address is the read address rebased from source to destination window.
        dst_addr_d   = rd_valid_q ? dst_base_q + (src_addr_q - src_base_q) : dst_addr_q;
        words_done_d = wr_valid_q ? words_done_q + LEN_WIDTH'(1) : words_done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    src_base_d   = src_base;
                    dst_base_d   = dst_base;
                    len_d        = len;
                    fill_d       = fill_value;
                    words_done_d = '0;
                    rd_cnt_d     = '0;
                    if (len != '0) begin
                        state_d    = S_RUN;
                        rd_valid_d = 1'b1;
                        src_en_d   = ~mode;
                        src_addr_d = src_base;
                        rd_cnt_d   = LEN_WIDTH'(1);
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (rd_cnt_q == len_q) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_valid_d = 1'b1;
                    src_en_d   = ~mode_q;
                    src_addr_d = src_addr_q + STEP;
                    rd_cnt_d   = rd_cnt_q + LEN_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = rd_valid_d | wr_valid_d;
    end

    always_ff @(posedge BRAM_CLK or negedge BRAM_RST) begin
        if (!BRAM_RST) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            src_base_q   <= '0;
            dst_base_q   <= '0;
            len_q        <= '0;
            fill_q       <= '0;
            rd_cnt_q     <= '0;
            src_addr_q   <= '0;
            rd_valid_q   <= 1'b0;
            src_en_q     <= 1'b0;
            dst_addr_q   <= '0;
            wr_valid_q   <= 1'b0;
            words_done_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            src_base_q   <= src_base_d;
            dst_base_q   <= dst_base_d;
            len_q        <= len_d;
            fill_q       <= fill_d;
            rd_cnt_q     <= rd_cnt_d;
            src_addr_q   <= src_addr_d;
            rd_valid_q   <= rd_valid_d;
            src_en_q     <= src_en_d;
            dst_addr_q   <= dst_addr_d;
            wr_valid_q   <= wr_valid_d;
            words_done_q <= words_done_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign words_done = words_done_q;
    assign SRC_ADDR   = src_addr_q;
    assign SRC_EN     = src_en_q;
    assign SRC_WE     = '0;
    assign DST_ADDR   = dst_addr_q;
    assign DST_EN     = wr_valid_q;
    assign DST_WE     = {BE_W{wr_valid_q}};
    assign DST_WRDATA = wr_valid_q ? (mode_q ? fill_q : SRC_RDDATA) : '0;

endmodule

// File: tb/tb_bram_copy_engine.sv
// Scoreboard bench for bram_copy_engine with behavioural source/destination BRAMs.
`timescale 1ns/1ps
module tb_bram_copy_engine;

    logic        BRAM_CLK = 1'b0;
    logic        BRAM_RST;
    logic        start, mode, abort;
    logic [14:0] src_base, dst_base;
    logic [12:0] len;
    logic [31:0] fill_value;
    logic        busy, done;
    logic [12:0] words_done;
    logic [14:0] SRC_ADDR, DST_ADDR;
    logic        SRC_EN, DST_EN;
    logic [3:0]  SRC_WE, DST_WE;
    logic [31:0] SRC_RDDATA, DST_WRDATA;

    bram_copy_engine #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .LEN_WIDTH(13)) dut (
        .BRAM_CLK(BRAM_CLK), .BRAM_RST(BRAM_RST), .start(start), .mode(mode),
        .src_base(src_base), .dst_base(dst_base), .len(len), .fill_value(fill_value),
        .abort(abort), .busy(busy), .done(done), .words_done(words_done),
        .SRC_ADDR(SRC_ADDR), .SRC_EN(SRC_EN), .SRC_WE(SRC_WE), .SRC_RDDATA(SRC_RDDATA),
        .DST_ADDR(DST_ADDR), .DST_EN(DST_EN), .DST_WE(DST_WE), .DST_WRDATA(DST_WRDATA)
    );

    always #5 BRAM_CLK = ~BRAM_CLK;

    logic [31:0] src_mem [0:8191];
    logic [31:0] dst_mem [0:8191];
    int cyc = 0;

    always @(posedge BRAM_CLK) begin
        cyc <= cyc + 1;
        if (SRC_EN) SRC_RDDATA <= src_mem[SRC_ADDR[14:2]];
        if (DST_WE != 4'h0) dst_mem[DST_ADDR[14:2]] <= DST_WRDATA;
    end

    int total = 0;
    int bad = 0;
    int start_cyc, done_at, done_cnt, wr_cnt, src_en_cnt, busy_cnt;
    logic [14:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected write per DST_WE cycle.
    always @(negedge BRAM_CLK) begin
        if (BRAM_RST) begin
            if (busy) busy_cnt++;
            if (SRC_EN) src_en_cnt++;
            if (done) begin
                done_cnt++;
                done_at = cyc - start_cyc;
            end
            if (DST_WE != 4'h0) begin
                wr_cnt++;
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_write", {17'h0, DST_ADDR, DST_WRDATA}, 64'h0);
                end else begin
                    chk("write_addr_data", {17'h0, DST_ADDR, DST_WRDATA},
                        {17'h0, exp_addr_q.pop_front(), exp_data_q.pop_front()});
                    chk("write_strobe", DST_WE, 4'hF);
                end
            end
        end
    end

    task automatic clear_counts();
        done_cnt = 0; done_at = -1; wr_cnt = 0; src_en_cnt = 0; busy_cnt = 0;
    endtask

    task automatic push_expected(input logic m, input logic [14:0] sb, input logic [14:0] db,
                                 input int n, input logic [31:0] fv);
        logic [14:0] sa, da;
        for (int k = 0; k < n; k++) begin
            sa = sb + 15'(k * 4);
            da = db + 15'(k * 4);
            exp_addr_q.push_back(da);
            exp_data_q.push_back(m ? fv : src_mem[sa[14:2]]);
        end
    endtask

    // abort_at: cycle to raise abort (0 = together with start, -1 = never);
    // restart_at: cycle to issue a second start that must be ignored (-1 = never).
    task automatic xfer(input string tag, input logic m, input logic [14:0] sb, input logic [14:0] db,
                        input logic [12:0] n, input logic [31:0] fv, input int abort_at,
                        input int restart_at, input int exp_wr, input int exp_done, input int exp_busy);
        bit seen;
        push_expected(m, sb, db, exp_wr, fv);
        clear_counts();
        @(posedge BRAM_CLK); #1;
        start = 1'b1; mode = m; src_base = sb; dst_base = db; len = n; fill_value = fv;
        abort = (abort_at == 0);
        start_cyc = cyc;
        seen = 1'b0;
        for (int c = 1; c <= int'(n) + 20; c++) begin
            @(posedge BRAM_CLK); #1;
            start = (c == restart_at);
            if (c == restart_at) begin
                len = 13'd3; src_base = 15'h0400; mode = ~m;
            end
            abort = (c == abort_at);
            if (done_cnt != 0) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0; abort = 1'b0;
        if (!seen) chk({tag, "_done_timeout"}, 0, 1);
        chk({tag, "_done_cycle"}, done_at, exp_done);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_words_done"}, words_done, exp_wr);
        chk({tag, "_write_count"}, wr_cnt, exp_wr);
        chk({tag, "_src_en_count"}, src_en_cnt, m ? 0 : exp_wr);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, "_queue_left"}, exp_addr_q.size(), 0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    initial begin
        BRAM_RST = 1'b0;
        start = 0; mode = 0; abort = 0; src_base = 0; dst_base = 0; len = 0; fill_value = 0;
        for (int i = 0; i < 8192; i++) begin
            src_mem[i] = 32'(i);
            dst_mem[i] = 32'hA5A5_0000 | 32'(i);
        end
        clear_counts();
        repeat (3) @(posedge BRAM_CLK);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dst_we", DST_WE, 0);
        chk("rst_words_done", words_done, 0);
        BRAM_RST = 1'b1;

        xfer("copy2048", 1'b0, 15'h0000, 15'h4000, 13'd2048, 32'h0, -1, -1, 2048, 2050, 2049);
        chk("copy_first", dst_mem[15'h4000 >> 2], 32'd0);
        chk("copy_last", dst_mem[(15'h4000 >> 2) + 2047], 32'd2047);

        xfer("fill5", 1'b1, 15'h0000, 15'h0100, 13'd5, 32'hDEADBEEF, -1, -1, 5, 7, 6);
        for (int a = 15'h40; a <= 15'h44; a++) chk("fill_mem", dst_mem[a], 32'hDEADBEEF);
        chk("fill_0x114_untouched", dst_mem[15'h45], 32'hA5A5_0045);

        xfer("wrap4", 1'b0, 15'h0200, 15'h7FF8, 13'd4, 32'h0, -1, -1, 4, 6, 5);
        chk("wrap_7ff8", dst_mem[13'h1FFE], 32'h80);
        chk("wrap_7ffc", dst_mem[13'h1FFF], 32'h81);
        chk("wrap_0000", dst_mem[0], 32'h82);
        chk("wrap_0004", dst_mem[1], 32'h83);

        xfer("len0", 1'b0, 15'h0000, 15'h1000, 13'd0, 32'h0, -1, -1, 0, 1, 0);
        xfer("busy_start", 1'b0, 15'h0010, 15'h1000, 13'd8, 32'h0, -1, 3, 8, 10, 9);
        xfer("abort", 1'b0, 15'h0000, 15'h2000, 13'd100, 32'h0, 10, -1, 10, 11, 11);
        xfer("start_abort", 1'b0, 15'h0020, 15'h3000, 13'd3, 32'h0, 0, -1, 3, 5, 4);

        // Reset in the middle of a 50-word copy.
        push_expected(1'b0, 15'h0000, 15'h6000, 50, 32'h0);
        clear_counts();
        @(posedge BRAM_CLK); #1;
        start = 1'b1; mode = 1'b0; src_base = 15'h0000; dst_base = 15'h6000; len = 13'd50;
        start_cyc = cyc;
        for (int c = 1; c <= 5; c++) begin
            @(posedge BRAM_CLK); #1;
            start = 1'b0;
        end
        BRAM_RST = 1'b0;
        #1;
        chk("mid_rst_outputs", {busy, done, SRC_EN, DST_EN, DST_WE, words_done, SRC_ADDR, DST_ADDR, DST_WRDATA}, 0);
        repeat (3) @(posedge BRAM_CLK);
        #1;
        chk("mid_rst_writes", wr_cnt, 3);
        exp_addr_q.delete();
        exp_data_q.delete();
        BRAM_RST = 1'b1;
        repeat (4) @(posedge BRAM_CLK);
        #1;
        chk("post_rst_no_writes", wr_cnt, 3);
        chk("src_we_tied", SRC_WE, 0);

        xfer("after_rst", 1'b1, 15'h0000, 15'h0300, 13'd4, 32'h1234_5678, -1, -1, 4, 6, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
